// File: rtl/medium_buffer_reader_pkg.sv
// Shared sizing, pointer type and occupancy helper for the buffer read path.
package medium_buffer_reader_pkg;

    localparam int unsigned MBR_DATA_W = 8;
    localparam int unsigned MBR_DEPTH  = 4;
    localparam int unsigned MBR_AW     = 2;
    localparam int unsigned MBR_PW     = MBR_AW + 1;

    // Output queue: two entries, count needs two bits to reach 2.
    localparam int unsigned QDEPTH = 2;
    localparam int unsigned QCNT_W = 2;

    typedef logic [MBR_AW:0] ptr_t;

    // Entries between two wrap-bit pointers.
    function automatic ptr_t occupancy(input ptr_t wr, input ptr_t rd);
        return ptr_t'(wr - rd);
    endfunction

endpackage

// File: rtl/medium_skid_queue.sv
// Two-entry valid/ready output FIFO; the head register drives the stream directly.
module medium_skid_queue
    import medium_buffer_reader_pkg::*;
#(
    parameter int unsigned DATA_W = MBR_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [QCNT_W-1:0] count
);

    logic [DATA_W-1:0] tail;
    logic [DATA_W-1:0] head_n;
    logic [DATA_W-1:0] tail_n;
    logic [QCNT_W-1:0] count_n;

    // Next-state: clear wins, then push/pop; a pop with a push lets the head advance.
    always_comb begin
        head_n  = out_data;
        tail_n  = tail;
        count_n = count;
        if (clear) begin
            count_n = '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == '0) begin
                        head_n = push_data;
                    end else begin
                        tail_n = push_data;
                    end
                    count_n = count + QCNT_W'(1);
                end
                2'b01: begin
                    head_n  = tail;
                    count_n = count - QCNT_W'(1);
                end
                2'b11: begin
                    if (count == QCNT_W'(1)) begin
                        head_n = push_data;
                    end else begin
                        head_n = tail;
                        tail_n = push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data  <= '0;
            tail      <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_data  <= head_n;
            tail      <= tail_n;
            count     <= count_n;
            out_valid <= (count_n != '0);
        end
    end

endmodule

// File: rtl/medium_buffer_reader.sv
// Drains the write buffer through a registered-read RAM port onto a valid/ready stream.
module medium_buffer_reader
    import medium_buffer_reader_pkg::*;
#(
    parameter int unsigned DATA_W = MBR_DATA_W,
    parameter int unsigned DEPTH  = MBR_DEPTH,
    parameter int unsigned AW     = MBR_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW:0]       wr_ptr,
    input  logic              flush,
    output logic              mem_rd,
    output logic [AW-1:0]     mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [AW:0]       rd_ptr,
    output logic              empty,
    output logic              full
);

    localparam int unsigned PW = AW + 1;

    logic [AW:0]       fptr;
    logic              inflight;
    logic [QCNT_W-1:0] qcount;
    logic              pop_c;
    logic              discard_c;
    logic              ret_c;
    logic              issue_c;
    logic [2:0]        pending_c;

    // A return that coincides with flush belongs to the discarded data.
    assign pop_c     = out_valid & out_ready;
    assign discard_c = inflight & flush;
    assign ret_c     = inflight & ~discard_c;

    // Queue slots already committed after this cycle's pop; keeps queue + in-flight <= 2.
    assign pending_c = 3'(qcount) + 3'(inflight) - 3'(pop_c);
    assign issue_c   = rst & (wr_ptr != fptr) & (pending_c < 3'd2) & ~flush;

    assign mem_rd   = issue_c;
    assign mem_addr = fptr[AW-1:0];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (occupancy(ptr_t'(wr_ptr), ptr_t'(rd_ptr)) == ptr_t'(DEPTH));

    // Fetch and consumed pointers; flush realigns both to the writer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fptr     <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue_c;
            if (flush) begin
                fptr   <= wr_ptr;
                rd_ptr <= wr_ptr;
            end else begin
                if (issue_c) begin
                    fptr <= fptr + PW'(1);
                end
                if (pop_c) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
        end
    end

    medium_skid_queue #(
        .DATA_W (DATA_W)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (ret_c),
        .push_data (mem_data),
        .pop       (pop_c),
        .out_valid (out_valid),
        .out_data  (out_data),
        .count     (qcount)
    );

endmodule

// File: tb/tb_medium_buffer_reader.sv
// Bench for medium_buffer_reader: RAM model, writer model and an in-order word scoreboard.
module tb_medium_buffer_reader;

    logic       clk;
    logic       rst;
    logic [2:0] wr_ptr;
    logic       flush;
    logic       mem_rd;
    logic [1:0] mem_addr;
    logic [7:0] mem_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] rd_ptr;
    logic       empty;
    logic       full;

    logic [7:0] ram [4];
    logic [2:0] m_wr;
    logic [2:0] m_rd;
    logic [7:0] sb [$];
    int checks;
    int errors;

    medium_buffer_reader dut (
        .clk       (clk),
        .rst       (rst),
        .wr_ptr    (wr_ptr),
        .flush     (flush),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rd_ptr    (rd_ptr),
        .empty     (empty),
        .full      (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read RAM: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= ram[mem_addr];
    end

    // Drive one cycle of inputs and advance the model by the words the writer adds and the consumer takes.
    task automatic drive(input bit we, input logic [7:0] d, input bit rdy, input bit fl);
        bit pop;
        pop = out_valid && rdy;
        if (we) begin
            ram[m_wr[1:0]] = d;
            sb.push_back(d);
            m_wr = m_wr + 3'd1;
        end
        wr_ptr = m_wr;
        out_ready = rdy;
        flush = fl;
        if (fl) begin
            sb.delete();
            m_rd = m_wr;
        end else if (pop) begin
            if (sb.size() > 0) sb.delete(0);
            m_rd = m_rd + 3'd1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        wr_ptr = 3'd0; flush = 1'b0; out_ready = 1'b0;
        m_wr = 3'd0; m_rd = 3'd0; sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        wr_ptr = 3'd0; flush = 1'b0; out_ready = 1'b0;
        m_wr = 3'd0; m_rd = 3'd0; sb.delete();
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (rd_ptr !== 3'd0) begin errors++; $display("FAIL reset_rd_ptr: got %0d expected 0", rd_ptr); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b expected 0", mem_rd); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", out_data); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_word();
        drive(1'b1, 8'hA5, 1'b1, 1'b0);
        #1;
        checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL single_mem_rd: got %b expected 1", mem_rd); end
        checks++; if (mem_addr !== 2'd0) begin errors++; $display("FAIL single_addr: got %0d expected 0", mem_addr); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", out_valid); end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", out_data); end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (rd_ptr !== 3'd1) begin errors++; $display("FAIL single_rd_ptr: got %0d expected 1", rd_ptr); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %b expected 1", empty); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_after_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_streaming();
        int n_wr, n_pop, n_iss, first_v, last_pop;
        logic [2:0] occ;
        do_reset();
        n_wr = 0; n_pop = 0; n_iss = 0; first_v = -1; last_pop = -1;
        for (int cyc = 0; cyc < 40 && n_pop < 6; cyc++) begin
            if (out_valid) begin
                if (first_v < 0) first_v = cyc;
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL stream_spurious: got %h expected no word", out_data); end
                else if (out_data !== sb[0]) begin errors++; $display("FAIL stream_data: got %h expected %h", out_data, sb[0]); end
                n_pop++; last_pop = cyc;
            end
            occ = m_wr - m_rd;
            if (n_wr < 6 && occ < 3'd4) begin
                drive(1'b1, 8'(8'h10 + n_wr), 1'b1, 1'b0);
                n_wr++;
            end else begin
                drive(1'b0, 8'h00, 1'b1, 1'b0);
            end
            #1;
            if (mem_rd) begin
                checks++; if (mem_addr !== 2'(n_iss)) begin errors++; $display("FAIL stream_addr: got %0d expected %0d", mem_addr, 2'(n_iss)); end
                n_iss++;
            end
            @(negedge clk);
        end
        checks++; if (n_pop != 6) begin errors++; $display("FAIL stream_count: got %0d expected 6", n_pop); end
        checks++; if (n_iss != 6) begin errors++; $display("FAIL stream_issues: got %0d expected 6", n_iss); end
        checks++; if (last_pop - first_v != 5) begin errors++; $display("FAIL stream_rate: got %0d expected 5", last_pop - first_v); end
        checks++; if (rd_ptr !== 3'd6) begin errors++; $display("FAIL stream_rd_ptr: got %0d expected 6", rd_ptr); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stream_empty: got %b expected 1", empty); end
    endtask

    task automatic test_backpressure();
        int n_pop;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b0);
            @(negedge clk);
            checks++; if (out_data !== 8'hB0) begin errors++; $display("FAIL bp_stable: got %h expected b0", out_data); end
        end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL bp_full: got %b expected 1", full); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL bp_mem_rd: got %b expected 0", mem_rd); end
        n_pop = 0;
        for (int i = 0; i < 20 && n_pop < 4; i++) begin
            if (out_valid) begin
                checks++; if (out_data !== 8'(8'hB0 + n_pop)) begin errors++; $display("FAIL bp_order: got %h expected %h", out_data, 8'(8'hB0 + n_pop)); end
                n_pop++;
            end
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            @(negedge clk);
        end
        checks++; if (n_pop != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", n_pop); end
        repeat (2) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            @(negedge clk);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b expected 0", out_valid); end
        checks++; if (rd_ptr !== 3'd2) begin errors++; $display("FAIL bp_rd_ptr: got %0d expected 2", rd_ptr); end
    endtask

    task automatic test_flush();
        int seen;
        drive(1'b1, 8'hC0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 8'hC1, 1'b0, 1'b0);
        #1;
        checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL flush_pre_rd: got %b expected 1", mem_rd); end
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        #1;
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL flush_mem_rd: got %b expected 0", mem_rd); end
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
        checks++; if (rd_ptr !== 3'd4) begin errors++; $display("FAIL flush_rd_ptr: got %0d expected 4", rd_ptr); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b expected 1", empty); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_late_valid: got %b expected 0", out_valid); end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) begin
                checks++; if (out_data !== 8'hD0) begin errors++; $display("FAIL flush_next_word: got %h expected d0", out_data); end
                seen++;
            end
            drive(i == 0, 8'hD0, 1'b1, 1'b0);
            @(negedge clk);
        end
        checks++; if (seen != 1) begin errors++; $display("FAIL flush_next_count: got %0d expected 1", seen); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'hE0 + i), 1'b1, 1'b0);
            @(negedge clk);
        end
        drive(1'b1, 8'hE3, 1'b1, 1'b0);
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid: got %b expected 1", out_valid); end
        checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL arst_pre_rd: got %b expected 1", mem_rd); end
        #1 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", out_valid); end
        checks++; if (rd_ptr !== 3'd0) begin errors++; $display("FAIL arst_rd_ptr: got %0d expected 0", rd_ptr); end
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL arst_mem_rd: got %b expected 0", mem_rd); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL arst_data: got %h expected 00", out_data); end
        do_reset();
    endtask

    task automatic test_random();
        logic [2:0] occ;
        bit we, rdy, fl;
        int guard;
        for (int c = 0; c < 400; c++) begin
            occ = m_wr - m_rd;
            checks++; if (rd_ptr !== m_rd) begin errors++; $display("FAIL rand_rd_ptr: got %0d expected %0d", rd_ptr, m_rd); end
            checks++; if (empty !== (occ == 3'd0)) begin errors++; $display("FAIL rand_empty: got %b expected %b", empty, occ == 3'd0); end
            checks++; if (full !== (occ == 3'd4)) begin errors++; $display("FAIL rand_full: got %b expected %b", full, occ == 3'd4); end
            if (out_valid) begin
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL rand_spurious: got %h expected no word", out_data); end
                else if (out_data !== sb[0]) begin errors++; $display("FAIL rand_data: got %h expected %h", out_data, sb[0]); end
            end
            we  = (occ < 3'd4) && ($urandom_range(2) != 0);
            rdy = ($urandom_range(3) != 0);
            fl  = ($urandom_range(49) == 0);
            drive(we, 8'($urandom), rdy, fl);
            @(negedge clk);
        end
        guard = 0;
        while (sb.size() != 0 && guard < 40) begin
            if (out_valid) begin
                checks++; if (out_data !== sb[0]) begin errors++; $display("FAIL rand_drain_data: got %h expected %h", out_data, sb[0]); end
            end
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            @(negedge clk);
            guard++;
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rand_drain_timeout: got %0d words left expected 0", sb.size()); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rand_final_empty: got %b expected 1", empty); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rand_final_valid: got %b expected 0", out_valid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        test_reset();
        test_single_word();
        test_streaming();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
